// File: rtl/cute_key_scheduler.sv
// cute_key_scheduler
//   Serially loads a schedule of NUM_KEYS keys (KEY_W bits each) and drives the
//   locked FSM's keyinput bus, presenting key k while the mirrored phase counter
//   is in slot k. All state updates on the falling clock edge, as the consumer does.
//
// Ports
//   clk          clock, state updates on negedge
//   rst          asynchronous active-high reset
//   clear        synchronous: discard the stored schedule, return to EMPTY
//   load_valid   serial key bit present on load_bit
//   load_bit     serial key bit (key 0 first, keyinput0 first within a key)
//   load_ready   a key bit is accepted this edge if load_valid is high
//   keys_loaded  full schedule stored (ARMED)
//   key_out      keyinput bus of the consumer; zero unless ARMED
//   slot_idx     current key slot = phase / SLOT_LEN
//   phase        phase counter, identical to the consumer's counter

module cute_key_scheduler #(
    parameter int unsigned KEY_W    = 6,
    parameter int unsigned NUM_KEYS = 2,
    parameter int unsigned SLOT_LEN = 6,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned SLOT_W   = 1,
    parameter int unsigned LCNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_valid,
    input  logic              load_bit,
    output logic              load_ready,
    output logic              keys_loaded,
    output logic [KEY_W-1:0]  key_out,
    output logic [SLOT_W-1:0] slot_idx,
    output logic [CNT_W-1:0]  phase
);

    localparam int unsigned Period = NUM_KEYS * SLOT_LEN;
    localparam int unsigned Total  = NUM_KEYS * KEY_W;

    typedef enum logic [1:0] {StEmpty, StLoading, StArmed} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        phase_q, phase_d;
    logic [Total-1:0]        store_q, store_d;
    logic [LCNT_W-1:0]       lcnt_q, lcnt_d;
    logic                    accept;

    // State register: phase free-runs regardless of FSM state or clear.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            phase_q <= '0;
            store_q <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            store_q <= store_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // clear has priority over an incoming bit; nothing is accepted once ARMED.
    assign accept = load_valid && !clear && (state_q != StArmed);

    // Next-state and datapath.
    always_comb begin
        phase_d = (phase_q >= CNT_W'(Period - 1)) ? '0 : phase_q + CNT_W'(1);
        state_d = state_q;
        store_d = store_q;
        lcnt_d  = lcnt_q;
        if (clear) begin
            state_d = StEmpty;
            store_d = '0;
            lcnt_d  = '0;
        end else if (accept) begin
            // Flat bit n is store[n / KEY_W][n % KEY_W].
            store_d[lcnt_q] = load_bit;
            lcnt_d          = lcnt_q + LCNT_W'(1);
            state_d         = (lcnt_q == LCNT_W'(Total - 1)) ? StArmed : StLoading;
        end
    end

    // Outputs depend on registered state only.
    always_comb begin
        load_ready  = (state_q != StArmed);
        keys_loaded = (state_q == StArmed);
        phase       = phase_q;
        // Constant-divisor compare chain instead of a divider.
        slot_idx = '0;
        for (int unsigned k = 1; k < NUM_KEYS; k++) begin
            if (phase_q >= CNT_W'(k * SLOT_LEN)) begin
                slot_idx = SLOT_W'(k);
            end
        end
        key_out = '0;
        if (state_q == StArmed) begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if (slot_idx == SLOT_W'(k)) begin
                    key_out = store_q[k*KEY_W +: KEY_W];
                end
            end
        end
    end

endmodule
